// File: rtl/rc4_stream_ctrl_if.sv
// Host-side streams of the rc4 sequencer: key bytes in, payload bytes in, processed bytes out.
// master drives the inputs of the controller, slave is the controller itself.
interface rc4_stream_ctrl_if;
  logic       k_valid;
  logic       k_ready;
  logic [7:0] k_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport master (
    output k_valid, k_data, s_valid, s_data, s_last, m_ready,
    input  k_ready, s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  k_valid, k_data, s_valid, s_data, s_last, m_ready,
    output k_ready, s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/rc4_stream_ctrl.sv
// Sequencer around the rc4 core: buffers a host key, replays it with the core's key-load timing,
// then steps the core once per payload byte and registers the result onto a valid/ready stream.
module rc4_stream_ctrl #(
  parameter int unsigned KEY_BYTES = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rc4_stream_ctrl_if.slave bus,
  output logic             c_key_valid,
  output logic [7:0]       c_key_input,
  output logic [7:0]       c_din,
  output logic             c_din_valid,
  input  logic [7:0]       c_dout,
  input  logic             c_ks_valid,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] KLast = KW'(KEY_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StKcollect, StKpulse, StKsend, StKwait, StRun} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    kcnt_q, kcnt_d;
  logic [7:0]       key_buf_q [KEY_BYTES];
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q;
  logic             m_last_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             in_frame_q;

  logic k_ready, s_ready, k_hs, s_hs;

  // Rekey is only allowed between frames so a frame never straddles two keys.
  assign k_ready = (state_q == StIdle) || (state_q == StKcollect) ||
                   ((state_q == StRun) && !in_frame_q);
  assign s_ready = (state_q == StRun) && (!m_valid_q || bus.m_ready);
  assign k_hs    = bus.k_valid && k_ready;
  assign s_hs    = bus.s_valid && s_ready;

  assign bus.k_ready = k_ready;
  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign frame_cnt   = frame_cnt_q;

  // One core step per accepted byte; din is forced to zero otherwise.
  assign c_din_valid = s_hs;
  assign c_din       = s_hs ? bus.s_data : 8'h00;

  always_comb begin
    state_d     = state_q;
    kcnt_d      = kcnt_q;
    c_key_valid = 1'b0;
    c_key_input = 8'h00;
    busy        = 1'b0;
    unique case (state_q)
      StIdle, StRun: begin
        if (k_hs) begin
          kcnt_d  = kcnt_q + KW'(1);
          state_d = StKcollect;
        end
      end
      StKcollect: begin
        busy = 1'b1;
        if (k_hs) begin
          kcnt_d = kcnt_q + KW'(1);
          if (kcnt_q == KLast) begin
            kcnt_d  = '0;
            state_d = StKpulse;
          end
        end
      end
      StKpulse: begin
        busy        = 1'b1;
        c_key_valid = 1'b1;
        kcnt_d      = '0;
        state_d     = StKsend;
      end
      StKsend: begin
        busy        = 1'b1;
        c_key_input = key_buf_q[kcnt_q];
        kcnt_d      = kcnt_q + KW'(1);
        if (kcnt_q == KLast) begin
          kcnt_d  = '0;
          state_d = StKwait;
        end
      end
      StKwait: begin
        busy = 1'b1;
        if (c_ks_valid) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    if (s_hs) begin
      m_valid_d = 1'b1;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      kcnt_q      <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= 8'h00;
      m_last_q    <= 1'b0;
      frame_cnt_q <= '0;
      in_frame_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      kcnt_q    <= kcnt_d;
      m_valid_q <= m_valid_d;
      if (s_hs) begin
        m_data_q    <= c_dout;
        m_last_q    <= bus.s_last;
        frame_cnt_q <= bus.s_last ? '0 : frame_cnt_q + CNT_W'(1);
        in_frame_q  <= !bus.s_last;
      end
    end
  end

  // Key storage needs no reset: it is always fully rewritten before it is replayed.
  always_ff @(posedge clk) begin
    if (k_hs) key_buf_q[kcnt_q] <= bus.k_data;
  end

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Bench for rc4_stream_ctrl with a behavioural rc4 core; expected bytes go to a scoreboard queue
// when a payload byte is accepted and are compared when the output stream delivers them.
module tb_rc4_stream_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc4_stream_ctrl_if bus();

  logic        c_key_valid, c_din_valid, c_ks_valid, busy;
  logic [7:0]  c_key_input, c_din, c_dout;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  rc4_stream_ctrl #(.KEY_BYTES(16), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .c_key_valid (c_key_valid),
    .c_key_input (c_key_input),
    .c_din       (c_din),
    .c_din_valid (c_din_valid),
    .c_dout      (c_dout),
    .c_ks_valid  (c_ks_valid),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  function automatic logic [511:0] rc4_ks(input logic [127:0] key);
    logic [7:0]   s [256];
    logic [7:0]   j, ii, t, tmp;
    logic [511:0] r;
    for (int i = 0; i < 256; i++) s[i] = i[7:0];
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      j    = j + s[i] + key[8*(i%16) +: 8];
      tmp  = s[i];
      s[i] = s[j];
      s[j] = tmp;
    end
    ii = 8'h00;
    j  = 8'h00;
    r  = '0;
    for (int n = 0; n < 64; n++) begin
      ii    = ii + 8'h01;
      j     = j + s[ii];
      tmp   = s[ii];
      s[ii] = s[j];
      s[j]  = tmp;
      t     = s[ii] + s[j];
      r[8*n +: 8] = s[t];
    end
    return r;
  endfunction

  // Behavioural core: captures the key on the 16 cycles after key_valid, then after a variable
  // delay raises key_stream_valid and XORs din with successive keystream bytes.
  logic [127:0] cap_key;
  logic [511:0] core_ks;
  logic [5:0]   core_ptr;
  logic         core_ks_valid;
  logic         cap_on;
  int           cap_n, delay, kv_pulses, din_steps;

  initial begin
    kv_pulses = 0;
    din_steps = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ks_valid <= 1'b0;
      cap_on        <= 1'b0;
      cap_n         <= 0;
      delay         <= 0;
      core_ptr      <= '0;
      core_ks       <= '0;
    end else begin
      if (c_key_valid) begin
        kv_pulses     <= kv_pulses + 1;
        cap_on        <= 1'b1;
        cap_n         <= 0;
        core_ks_valid <= 1'b0;
      end else if (cap_on) begin
        cap_key[8*cap_n +: 8] <= c_key_input;
        cap_n <= cap_n + 1;
        if (cap_n == 15) begin
          cap_on <= 1'b0;
          delay  <= $urandom_range(20, 60);
        end
      end else if (delay > 0) begin
        delay <= delay - 1;
        if (delay == 1) begin
          core_ks_valid <= 1'b1;
          core_ks       <= rc4_ks(cap_key);
          core_ptr      <= '0;
        end
      end
      if (c_din_valid) begin
        din_steps <= din_steps + 1;
        if (core_ks_valid) core_ptr <= core_ptr + 6'd1;
      end
    end
  end

  assign c_ks_valid = core_ks_valid;
  assign c_dout     = c_din ^ core_ks[8*core_ptr +: 8];

  logic [8:0]   exp_q [$];
  logic [127:0] cur_key;
  logic [511:0] gold;
  int           gidx;

  localparam logic [127:0] KeyA = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] KeyB = 128'h3c6ef372a54ff53a510e527f9b05688c;

  task automatic apply_reset();
    rst_n       = 1'b0;
    bus.k_valid = 1'b0;
    bus.k_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    logic [45:0] obs;
    obs = {bus.m_valid, bus.s_ready, busy, c_key_valid, c_din_valid, c_key_input, c_din,
           bus.m_data, bus.m_last, frame_cnt};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL %s outputs=%h required=0", name, obs);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    check_all_zero("reset_outputs");
    checks++;
    if (bus.k_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_k_ready got=%b required=1", bus.k_ready);
    end
  endtask

  task automatic send_key(input logic [127:0] key, input int first, input bit gaps);
    int t;
    for (int b = first; b < 16; b++) begin
      if (gaps) begin
        bus.k_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      bus.k_valid = 1'b1;
      bus.k_data  = key[8*b +: 8];
      t = 0;
      #1;
      while (!bus.k_ready && t < 50) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t == 50) begin
        checks++;
        errors++;
        $display("FAIL key_byte_accept byte=%0d got=timeout required=k_ready", b);
      end
      @(negedge clk);
    end
    bus.k_valid = 1'b0;
  endtask

  task automatic test_key_load(input logic [127:0] key, input int first, input bit gaps);
    int p0, cyc, bad_sready;
    p0 = kv_pulses;
    cur_key = key;
    gold = rc4_ks(key);
    gidx = 0;
    exp_q.delete();
    send_key(key, first, gaps);
    #1;
    checks++;
    if (bus.k_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL key_done_k_ready_busy got=%b%b required=01", bus.k_ready, busy);
    end
    cyc = 0;
    bad_sready = 0;
    while (busy && cyc < 300) begin
      if (bus.s_ready) bad_sready++;
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc >= 300) begin
      errors++;
      $display("FAIL key_wait_timeout got=busy_stuck required=busy_low");
    end
    checks++;
    if (bad_sready != 0) begin
      errors++;
      $display("FAIL s_ready_while_busy got=%0d required=0", bad_sready);
    end
    checks++;
    if (kv_pulses - p0 != 1) begin
      errors++;
      $display("FAIL key_valid_pulses got=%0d required=1", kv_pulses - p0);
    end
    checks++;
    if (cap_key !== key) begin
      errors++;
      $display("FAIL key_sequence got=%h required=%h", cap_key, key);
    end
    checks++;
    if (bus.s_ready !== 1'b1 || c_ks_valid !== 1'b1) begin
      errors++;
      $display("FAIL run_entry s_ready/ks_valid got=%b%b required=11", bus.s_ready, c_ks_valid);
    end
  endtask

  task automatic run_frame(input string name, input int n, input bit toggle, input int rekey_at,
                           output bit key_taken, output logic [63:0] rec);
    int sent, got, cyc, stalls, d0;
    bit kt_now;
    logic [8:0] e;
    sent = 0; got = 0; cyc = 0; stalls = 0;
    d0 = din_steps;
    key_taken = 1'b0;
    kt_now = 1'b0;
    rec = '0;
    bus.k_data = cur_key[7:0];
    while ((sent < n || exp_q.size() > 0 || bus.m_valid) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      kt_now      = 1'b0;
      bus.m_ready = toggle ? cyc[0] : 1'b1;
      bus.s_valid = (sent < n);
      bus.s_data  = 8'h41 + 8'(sent);
      bus.s_last  = (sent == n - 1);
      bus.k_valid = (rekey_at >= 0) && (sent >= rekey_at) && !key_taken;
      #1;
      if (bus.k_valid) begin
        checks++;
        if (bus.k_ready !== !(sent > 0 && sent < n)) begin
          errors++;
          $display("FAIL %s k_ready sent=%0d got=%b", name, sent, bus.k_ready);
        end
        if (bus.k_ready) begin
          key_taken = 1'b1;
          kt_now    = 1'b1;
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_byte got=%h required=none", name, bus.m_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.m_last, bus.m_data} !== e) begin
            errors++;
            $display("FAIL %s byte%0d got=%h required=%h", name, got, {bus.m_last, bus.m_data}, e);
          end
        end
        rec[8*got +: 8] = bus.m_data;
        got++;
      end
      if (bus.s_valid && bus.s_ready) begin
        checks++;
        if (c_din_valid !== 1'b1 || c_din !== bus.s_data) begin
          errors++;
          $display("FAIL %s core_din got=%b/%h required=1/%h", name, c_din_valid, c_din,
                   bus.s_data);
        end
        exp_q.push_back({bus.s_last, bus.s_data ^ gold[8*gidx +: 8]});
        gidx++;
        sent++;
      end else if (bus.s_valid) begin
        stalls++;
      end
    end
    if (kt_now) @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.k_valid = 1'b0;
    checks++;
    if (cyc >= 200 || got != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s completion got=%0d bytes required=%0d", name, got, n);
    end
    checks++;
    if (din_steps - d0 != n) begin
      errors++;
      $display("FAIL %s din_valid_count got=%0d required=%0d", name, din_steps - d0, n);
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s frame_cnt_end got=%0d required=0", name, frame_cnt);
    end
    if (!toggle && rekey_at < 0) begin
      checks++;
      if (stalls != 0) begin
        errors++;
        $display("FAIL %s back_to_back stalls got=%0d required=0", name, stalls);
      end
    end
  endtask

  task automatic test_refused(input string name);
    int bad;
    bad = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h55;
    bus.s_last  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bus.s_ready || c_din_valid || bus.m_valid) bad++;
    end
    bus.s_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s frame_accepted_without_key got=%0d required=0", name, bad);
    end
  endtask

  task automatic test_reset_ksend();
    send_key(KeyB, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (c_key_input !== KeyB[15:8] || busy !== 1'b1) begin
      errors++;
      $display("FAIL ksend_byte1 got=%h required=%h", c_key_input, KeyB[15:8]);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_ksend");
    @(negedge clk);
    rst_n = 1'b1;
    test_refused("after_ksend_reset");
  endtask

  task automatic test_reset_run();
    test_key_load(KeyB, 0, 1'b0);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h99;
    bus.s_last  = 1'b0;
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1;
    checks++;
    if (bus.m_valid !== 1'b1 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL held_byte got=%b/%0d required=1/1", bus.m_valid, frame_cnt);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_run");
    @(negedge clk);
    rst_n = 1'b1;
    test_refused("after_run_reset");
  endtask

  initial begin
    bit          kt;
    logic [63:0] out_a, out_b, out_c;
    test_reset();
    test_key_load(KeyA, 0, 1'b0);
    run_frame("frame_stream", 8, 1'b0, -1, kt, out_a);
    run_frame("frame_toggle", 8, 1'b1, -1, kt, out_b);
    test_key_load(KeyA, 0, 1'b1);
    run_frame("frame_rekey", 8, 1'b0, 3, kt, out_b);
    checks++;
    if (kt !== 1'b1) begin
      errors++;
      $display("FAIL rekey_byte0_taken got=%b required=1", kt);
    end
    test_key_load(KeyA, 1, 1'b1);
    run_frame("frame_replay", 8, 1'b0, -1, kt, out_c);
    checks++;
    if (out_c !== out_a) begin
      errors++;
      $display("FAIL replay_identical got=%h required=%h", out_c, out_a);
    end
    test_reset_ksend();
    test_reset_run();
    test_key_load(KeyB, 0, 1'b0);
    run_frame("frame_after_reset", 5, 1'b1, -1, kt, out_c);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
